// File: rtl/sram_a_loader_pkg.sv
// Shared definitions for the SRAM_a frame loader.
// Contents:
//   loader_state_e     - loader FSM encoding (IDLE/LOAD/LAST/DONE)
//   NUM_BANKS          - number of SRAM_a banks (3x3 arrangement)
//   NUM_LANES          - pixels per SRAM word (2x2 block)
//   calc_bpr()         - banked words per block-row for a given image width
//   lane_to_mask()     - active-low byte mask that writes a single lane
package sram_a_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } loader_state_e;

  localparam int NUM_BANKS = 9;
  localparam int NUM_LANES = 4;

  // Each bank column holds every third 2x2 block of a block-row, so a
  // block-row spans ceil((IMG_W/2)/3) words in each bank.
  function automatic int calc_bpr(input int img_w);
    return (img_w / 2 + 2) / 3;
  endfunction

  // Lane 0 lives in the most significant byte, so it is cleared at bit 3.
  function automatic logic [3:0] lane_to_mask(input logic [1:0] lane);
    logic [3:0] mask;
    mask = 4'hF;
    mask[2'd3 - lane] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/sram_a.sv


// File: rtl/sram_a_addr_map.sv
// Combinational pixel-coordinate to SRAM_a location mapping.
// Ports:
//   row   in  - pixel row
//   col   in  - pixel column
//   bank  out - target bank 0..8, (br%3)*3 + (bc%3) with br=row/2, bc=col/2
//   waddr out - word address, (br/3)*BPR + (bc/3)
//   lane  out - byte lane inside the 2x2 word, (row%2)*2 + (col%2)
module sram_a_addr_map
  import sram_a_loader_pkg::*;
#(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int ROW_W      = 5,
  parameter int COL_W      = 5
) (
  input  logic [ROW_W-1:0]      row,
  input  logic [COL_W-1:0]      col,
  output logic [3:0]            bank,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [1:0]            lane
);

  localparam int BPR = calc_bpr(IMG_W);

  logic [ROW_W-1:0] br_s;
  logic [COL_W-1:0] bc_s;
  logic [ROW_W-1:0] br_mod_s;
  logic [COL_W-1:0] bc_mod_s;
  logic [ROW_W-1:0] br_div_s;
  logic [COL_W-1:0] bc_div_s;

  // Block coordinates and their split into bank index and in-bank position.
  always_comb begin
    br_s     = row >> 1;
    bc_s     = col >> 1;
    br_mod_s = br_s % ROW_W'(3);
    bc_mod_s = bc_s % COL_W'(3);
    br_div_s = br_s / ROW_W'(3);
    bc_div_s = bc_s / COL_W'(3);
  end

  // Final bank, address and lane.
  always_comb begin
    bank  = 4'(br_mod_s) * 4'd3 + 4'(bc_mod_s);
    waddr = ADDR_WIDTH'(br_div_s) * ADDR_WIDTH'(BPR) + ADDR_WIDTH'(bc_div_s);
    lane  = {row[0], col[0]};
  end

endmodule

// File: rtl/sram_a_loader.sv
// Front-end writer for the nine SRAM_a banks used by CONV1.
// Takes a raster-order pixel stream over valid/ready and issues one
// byte-masked write per accepted pixel, one cycle after the accept.
// Ports:
//   clk, srstn                 - clock, async active-low reset
//   load_start                 - pulse in IDLE starts a frame load
//   pixel_valid, pixel_data    - pixel stream input (row-major)
//   pixel_ready                - loader accepts a pixel this cycle
//   sram_write_enable_a0..a8   - per-bank write enable, active-low
//   sram_bytemask_a            - byte mask, active-low
//   sram_waddr_a, sram_wdata_a - shared write address / data
//   busy                       - loader is not IDLE
//   load_done                  - one-cycle pulse once the frame is resident
module sram_a_loader
  import sram_a_loader_pkg::*;
#(
  parameter int IMG_W                  = 32,
  parameter int IMG_H                  = 32,
  parameter int DATA_WIDTH             = 8,
  parameter int DATA_NUM_PER_SRAM_ADDR = 4,
  parameter int ADDR_WIDTH             = 10
) (
  input  logic                                     clk,
  input  logic                                     srstn,
  input  logic                                     load_start,
  input  logic                                     pixel_valid,
  input  logic [DATA_WIDTH-1:0]                    pixel_data,
  output logic                                     pixel_ready,
  output logic                                     sram_write_enable_a0,
  output logic                                     sram_write_enable_a1,
  output logic                                     sram_write_enable_a2,
  output logic                                     sram_write_enable_a3,
  output logic                                     sram_write_enable_a4,
  output logic                                     sram_write_enable_a5,
  output logic                                     sram_write_enable_a6,
  output logic                                     sram_write_enable_a7,
  output logic                                     sram_write_enable_a8,
  output logic [3:0]                               sram_bytemask_a,
  output logic [ADDR_WIDTH-1:0]                    sram_waddr_a,
  output logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_wdata_a,
  output logic                                     busy,
  output logic                                     load_done
);

  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int WORD_W = DATA_NUM_PER_SRAM_ADDR * DATA_WIDTH;

  loader_state_e         state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [NUM_BANKS-1:0]  we_q, we_d;
  logic [3:0]            mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;

  logic                  accept_s;
  logic                  last_col_s;
  logic                  last_px_s;
  logic [3:0]            map_bank_s;
  logic [ADDR_WIDTH-1:0] map_waddr_s;
  logic [1:0]            map_lane_s;

  sram_a_addr_map #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ROW_W      (ROW_W),
    .COL_W      (COL_W)
  ) u_addr_map (
    .row   (row_q),
    .col   (col_q),
    .bank  (map_bank_s),
    .waddr (map_waddr_s),
    .lane  (map_lane_s)
  );

  // Handshake qualifiers; ready is registered and high exactly in LOAD.
  always_comb begin
    accept_s   = (state_q == ST_LOAD) & pixel_valid;
    last_col_s = (col_q == COL_W'(IMG_W - 1));
    last_px_s  = last_col_s & (row_q == ROW_W'(IMG_H - 1));
  end

  // Next state and raster counters.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          row_d   = '0;
          col_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          if (last_px_s) begin
            // Clear rather than wrap: row would overflow for power-of-2 heights.
            state_d = ST_LAST;
            row_d   = '0;
            col_d   = '0;
          end else if (last_col_s) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LAST: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered output values; address/data hold between strobes.
  always_comb begin
    we_d    = '1;
    mask_d  = 4'hF;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (accept_s) begin
      we_d    = ~(NUM_BANKS'(1) << map_bank_s);
      mask_d  = lane_to_mask(map_lane_s);
      waddr_d = map_waddr_s;
      wdata_d = {DATA_NUM_PER_SRAM_ADDR{pixel_data}};
    end else begin
      we_d   = '1;
      mask_d = 4'hF;
    end
    ready_d = (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= '1;
      mask_q  <= 4'hF;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign pixel_ready          = ready_q;
  assign busy                 = busy_q;
  assign load_done            = done_q;
  assign sram_bytemask_a      = mask_q;
  assign sram_waddr_a         = waddr_q;
  assign sram_wdata_a         = wdata_q;
  assign sram_write_enable_a0 = we_q[0];
  assign sram_write_enable_a1 = we_q[1];
  assign sram_write_enable_a2 = we_q[2];
  assign sram_write_enable_a3 = we_q[3];
  assign sram_write_enable_a4 = we_q[4];
  assign sram_write_enable_a5 = we_q[5];
  assign sram_write_enable_a6 = we_q[6];
  assign sram_write_enable_a7 = we_q[7];
  assign sram_write_enable_a8 = we_q[8];

endmodule

// File: tb/tb_sram_a_loader.sv
// Directed/self-checking bench for sram_a_loader (32x32 frame).
module tb_sram_a_loader;

  logic        clk = 1'b0;
  logic        srstn = 1'b0;
  logic        load_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [7:0]  pixel_data = 8'h00;
  logic        pixel_ready;
  logic        we0, we1, we2, we3, we4, we5, we6, we7, we8;
  logic [3:0]  sram_bytemask_a;
  logic [9:0]  sram_waddr_a;
  logic [31:0] sram_wdata_a;
  logic        busy;
  logic        load_done;

  logic [8:0]  we_vec;
  logic [54:0] obs_s;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cur_r = 0;
  int          cur_c = 0;
  int          acc_cnt = 0;
  bit          in_load = 1'b0;
  logic [9:0]  last_waddr = 10'd0;
  logic [31:0] last_wdata = 32'd0;
  int          strobe_cnt = 0;
  int          done_cnt = 0;

  sram_a_loader dut (
    .clk                  (clk),
    .srstn                (srstn),
    .load_start           (load_start),
    .pixel_valid          (pixel_valid),
    .pixel_data           (pixel_data),
    .pixel_ready          (pixel_ready),
    .sram_write_enable_a0 (we0),
    .sram_write_enable_a1 (we1),
    .sram_write_enable_a2 (we2),
    .sram_write_enable_a3 (we3),
    .sram_write_enable_a4 (we4),
    .sram_write_enable_a5 (we5),
    .sram_write_enable_a6 (we6),
    .sram_write_enable_a7 (we7),
    .sram_write_enable_a8 (we8),
    .sram_bytemask_a      (sram_bytemask_a),
    .sram_waddr_a         (sram_waddr_a),
    .sram_wdata_a         (sram_wdata_a),
    .busy                 (busy),
    .load_done            (load_done)
  );

  always #5 clk = ~clk;

  assign we_vec = {we8, we7, we6, we5, we4, we3, we2, we1, we0};
  assign obs_s  = {we_vec, sram_bytemask_a, sram_waddr_a, sram_wdata_a};

  // Count write strobes and done pulses on the falling edge.
  always @(negedge clk) begin
    if (we_vec != 9'h1FF) strobe_cnt <= strobe_cnt + 1;
    if (load_done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference strobe for pixel (r,c) of a 32x32 frame (6 words per block-row).
  function automatic logic [54:0] exp_strobe(input int r, input int c, input logic [7:0] d);
    int br, bc, bank, wa, lane;
    logic [8:0] we;
    logic [3:0] m;
    br   = r / 2;
    bc   = c / 2;
    bank = (br % 3) * 3 + (bc % 3);
    wa   = (br / 3) * 6 + (bc / 3);
    lane = (r % 2) * 2 + (c % 2);
    we   = 9'h1FF;
    we[bank] = 1'b0;
    m    = 4'hF;
    m[3 - lane] = 1'b0;
    return {we, m, 10'(wa), {4{d}}};
  endfunction

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic drive(input logic v, input logic [7:0] d, input logic ls);
    logic acc;
    logic [54:0] e;
    check_eq("ready", {63'd0, pixel_ready}, {63'd0, in_load});
    pixel_valid = v;
    pixel_data  = d;
    load_start  = ls;
    acc = v & in_load;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    load_start  = 1'b0;
    if (acc) begin
      e = exp_strobe(cur_r, cur_c, d);
      last_waddr = e[41:32];
      last_wdata = e[31:0];
      acc_cnt++;
      if (cur_r == 31 && cur_c == 31) begin
        in_load = 1'b0;
        cur_r = 0;
        cur_c = 0;
      end else if (cur_c == 31) begin
        cur_c = 0;
        cur_r++;
      end else begin
        cur_c++;
      end
    end else begin
      e = {9'h1FF, 4'hF, last_waddr, last_wdata};
    end
    check_eq("strobe", {9'd0, obs_s}, {9'd0, e});
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    in_load = 1'b1;
    cur_r = 0;
    cur_c = 0;
    acc_cnt = 0;
    check_eq("start_busy", {63'd0, busy}, 64'd1);
  endtask

  initial begin
    int pr, pc, prev, cyc, base_s, base_d;
    logic v;
    logic [7:0] d;

    // Reset state
    #12;
    check_eq("rst_outputs", {9'd0, obs_s}, {9'd0, 9'h1FF, 4'hF, 10'd0, 32'd0});
    check_eq("rst_ready", {63'd0, pixel_ready}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, load_done}, 64'd0);
    @(posedge clk);
    #1;
    srstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("idle_ready", {63'd0, pixel_ready}, 64'd0);
      check_eq("idle_busy", {63'd0, busy}, 64'd0);
    end

    // Full frame with random gaps, one mid-frame load_start
    start_load();
    base_s = strobe_cnt;
    base_d = done_cnt;
    cyc = 0;
    while (acc_cnt < 1024 && cyc < 4000) begin
      pr = cur_r;
      pc = cur_c;
      v  = ($urandom_range(0, 3) != 0) || (pr == 0 && pc == 0);
      if (pr == 0 && pc == 0) d = 8'h11;
      else if (pr == 1 && pc == 3) d = 8'hA5;
      else d = 8'($urandom_range(0, 255));
      prev = acc_cnt;
      drive(v, d, (acc_cnt == 100) ? v : 1'b0);
      cyc++;
      if (acc_cnt != prev) begin
        if (pr == 0 && pc == 0) begin
          check_eq("p00_we", {55'd0, we_vec}, {55'd0, 9'h1FE});
          check_eq("p00_waddr", {54'd0, sram_waddr_a}, 64'd0);
          check_eq("p00_mask", {60'd0, sram_bytemask_a}, {60'd0, 4'b0111});
          check_eq("p00_wdata", {32'd0, sram_wdata_a}, {32'd0, 32'h11111111});
        end
        if (pr == 1 && pc == 3) begin
          check_eq("p13_we", {55'd0, we_vec}, {55'd0, 9'h1FD});
          check_eq("p13_waddr", {54'd0, sram_waddr_a}, 64'd0);
          check_eq("p13_mask", {60'd0, sram_bytemask_a}, {60'd0, 4'b1110});
          check_eq("p13_wdata", {32'd0, sram_wdata_a}, {32'd0, 32'hA5A5A5A5});
        end
        if (pr == 6 && pc == 7) begin
          check_eq("p67_we", {55'd0, we_vec}, {55'd0, 9'h1FE});
          check_eq("p67_waddr", {54'd0, sram_waddr_a}, 64'd7);
          check_eq("p67_mask", {60'd0, sram_bytemask_a}, {60'd0, 4'b1011});
        end
        if (pr == 31 && pc == 31) begin
          check_eq("plast_we", {55'd0, we_vec}, {55'd0, 9'h1FE});
          check_eq("plast_waddr", {54'd0, sram_waddr_a}, 64'd35);
          check_eq("plast_mask", {60'd0, sram_bytemask_a}, {60'd0, 4'b1110});
        end
      end
    end
    check_eq("frame_accepts", 64'(acc_cnt), 64'd1024);
    // LAST: strobe on outputs, not ready, still busy
    check_eq("last_busy", {63'd0, busy}, 64'd1);
    check_eq("last_done", {63'd0, load_done}, 64'd0);
    // pixel_valid in LAST must be ignored
    drive(1'b1, 8'h77, 1'b0);
    check_eq("done_pulse", {63'd0, load_done}, 64'd1);
    check_eq("done_busy", {63'd0, busy}, 64'd1);
    drive(1'b0, 8'h00, 1'b0);
    check_eq("after_done", {63'd0, load_done}, 64'd0);
    check_eq("after_busy", {63'd0, busy}, 64'd0);
    check_eq("strobe_count", 64'(strobe_cnt - base_s), 64'd1024);
    check_eq("done_count", 64'(done_cnt - base_d), 64'd1);

    // Async reset after 500 accepts
    start_load();
    for (int i = 0; i < 500; i++) drive(1'b1, 8'(i), 1'b0);
    pixel_valid = 1'b1;
    pixel_data  = 8'hEE;
    #3;
    srstn = 1'b0;
    #1;
    check_eq("arst_outputs", {9'd0, obs_s}, {9'd0, 9'h1FF, 4'hF, 10'd0, 32'd0});
    check_eq("arst_ready", {63'd0, pixel_ready}, 64'd0);
    check_eq("arst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check_eq("arst_nostrobe", {9'd0, obs_s}, {9'd0, 9'h1FF, 4'hF, 10'd0, 32'd0});
    pixel_valid = 1'b0;
    srstn = 1'b1;
    in_load = 1'b0;
    last_waddr = 10'd0;
    last_wdata = 32'd0;
    @(posedge clk);
    #1;
    start_load();
    drive(1'b1, 8'h5A, 1'b0);
    check_eq("restart_we", {55'd0, we_vec}, {55'd0, 9'h1FE});
    check_eq("restart_waddr", {54'd0, sram_waddr_a}, 64'd0);
    check_eq("restart_mask", {60'd0, sram_bytemask_a}, {60'd0, 4'b0111});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_a_loader.md
Name: sram_a_loader

Overview:
- Front-end writer for the nine SRAM_a banks that the convolution engine reads during CONV1.
- Accepts a raster-order 8-bit pixel stream over a valid/ready handshake.
- Maps each pixel into the 3x3-bank, 2x2-pixel-per-word layout and issues one byte-masked write per pixel.
- Pulses load_done when the frame is resident; the top level uses it to launch conv_start.

Parameters:
IMG_W, 32, image width in pixels (even, >=2)
IMG_H, 32, image height in pixels (even, >=2)
DATA_WIDTH, 8, pixel width
DATA_NUM_PER_SRAM_ADDR, 4, pixels per SRAM word (2x2 block)
ADDR_WIDTH, 10, SRAM_a address width

Ports:
clk  input  1  clock, rising edge
srstn  input  1  reset, asynchronous assert, active-low
load_start  input  1  one-cycle pulse; begins frame load
pixel_valid  input  1  pixel_data valid
pixel_data  input  DATA_WIDTH  pixel, raster order (row-major)
pixel_ready  output  1  loader accepts pixel this cycle
sram_write_enable_a0 .. sram_write_enable_a8  output  1 each  per-bank write enable, active-low
sram_bytemask_a  output  4  byte mask, active-low (0 = write lane)
sram_waddr_a  output  ADDR_WIDTH  write address, shared by all banks
sram_wdata_a  output  DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH  write data
busy  output  1  high in any state other than IDLE
load_done  output  1  one-cycle pulse: frame fully written

Behaviour:
- Reset:
  - Reset is asynchronous and active-low (srstn).
  - State IDLE; row/col counters 0.
  - All write enables 1; bytemask 4'b1111; waddr 0; wdata 0.
  - pixel_ready 0; busy 0; load_done 0.
- States:
  - IDLE: load_start -> LOAD; counters cleared.
  - LOAD: pixel_ready=1; accept = pixel_valid & pixel_ready. Each accept advances col; when col wraps at IMG_W-1, col returns to 0 and row increments. Accepting pixel (IMG_H-1, IMG_W-1) -> LAST.
  - LAST: pixel_ready=0; the final write strobe is on the outputs -> DONE.
  - DONE: load_done=1 for one cycle -> IDLE.
- load_start outside IDLE is ignored. pixel_valid outside LOAD is ignored: no write, no counter change.
- Address mapping for pixel (r,c):
  - br=r/2, bc=c/2
  - bank=(br%3)*3+(bc%3)
  - BPR=(IMG_W/2+2)/3; waddr=(br/3)*BPR+(bc/3)
  - lane=(r%2)*2+(c%2)
  - Lane 0 occupies wdata[31:24], lane 3 occupies [7:0].
- Write path, fully registered, latency 1:
  - An accept in cycle t drives cycle t+1 only: sram_write_enable_a<bank>=0 (others 1), waddr, and bytemask with only bit (3-lane) cleared.
  - wdata = pixel replicated in all four lanes.
  - Cycle t+1 with no accept in t: all enables 1 and bytemask 4'b1111. waddr/wdata hold their previous values.
- Throughput: one pixel per cycle; gaps in pixel_valid produce idle write cycles only.
- load_done timing: asserted exactly 2 cycles after the last accept (one cycle after the last write strobe).
- srstn asserted mid-frame: outputs go to reset values immediately; no partial write is completed. A new load_start restarts at pixel (0,0).
- Counters use ceil(log2) widths. For 32x32 the address range is 0..35, and all arithmetic fits in ADDR_WIDTH without wrap.

Decomposition:
- Shared package: state encoding (IDLE/LOAD/LAST/DONE), BPR derivation, lane-to-mask function, bank count (9).
- One natural sub-module, sram_a_addr_map: combinational (row,col) -> (bank, waddr, lane).
- The loader owns the handshake, counters, FSM and output registers.

Test Plan:
- Hold srstn=0 -> all enables 1, bytemask 4'b1111, pixel_ready 0, busy 0, load_done 0. Release, no load_start -> pixel_ready stays 0.
- load_start, then pixel (0,0)=8'h11 -> next cycle we_a0=0, waddr=0, bytemask 4'b0111, wdata 32'h11111111.
- Stream row 0 then pixel (1,3)=8'hA5 -> we_a1=0, waddr=0, bytemask 4'b1110. Pixel (6,7) -> we_a0=0, waddr=7, bytemask 4'b1011.
- Full 32x32 frame with random pixel_valid gaps -> exactly 1024 write strobes, each matching a reference model.
  - Last pixel (31,31): we_a0=0, waddr=35, bytemask 4'b1110.
  - load_done exactly once, 2 cycles after the last accept; busy falls in the same cycle load_done falls.
- load_start pulsed mid-LOAD -> counters unaffected, frame completes normally.
- srstn low asynchronously after 500 accepts (between clock edges) -> outputs reset immediately, no strobe on the next edge. New load_start -> first write targets bank 0, waddr 0, lane 0.
